// File: rtl/gray_decoder_monitor_if.sv
// Bundle of the Gray count input, the error-clear control and the monitor status outputs.
// The master side drives the Gray bus and the clear; the slave side is the monitor.
interface gray_decoder_monitor_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    logic [N-1:0]     gray_in;
    logic             clear_err;
    logic [N-1:0]     bin_out;
    logic             bin_valid;
    logic             locked;
    logic             step_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output gray_in, clear_err,
        input  bin_out, bin_valid, locked, step_err, err_count
    );

    modport slave (
        input  gray_in, clear_err,
        output bin_out, bin_valid, locked, step_err, err_count
    );
endinterface

// File: rtl/gray_decoder_monitor.sv
// Gray-to-binary receiver that checks each sample is a hold or a +1 step and tracks lock.
// Define GRAY_SYNC_EN to pass gray_in through a 2-flop synchronizer before conversion.
module gray_decoder_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    gray_decoder_monitor_if.slave bus
);
    localparam int OKW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [OKW-1:0]   ok_cnt_reg, ok_cnt_next;
    logic [N-1:0]     bin_reg, bin_next;
    logic             valid_reg, valid_next;
    logic             step_err_reg, step_err_next;
    logic [ERR_W-1:0] err_reg, err_next;

    logic [N-1:0]     sample;
    logic             sample_ready;
    logic [N-1:0]     bin_comb;
    logic [N-1:0]     delta;
    logic             good_step;
    logic             hold_step;
    logic             err_event;

`ifdef GRAY_SYNC_EN
    logic [N-1:0] sync1_reg, sync2_reg;
    logic [1:0]   fill_reg;

    // fill_reg holds off the first load until sync2 carries a real post-reset sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            fill_reg  <= 2'd0;
        end else begin
            sync1_reg <= bus.gray_in;
            sync2_reg <= sync1_reg;
            if (fill_reg != 2'd2)
                fill_reg <= fill_reg + 2'd1;
        end
    end

    assign sample       = sync2_reg;
    assign sample_ready = (fill_reg == 2'd2);
`else
    assign sample       = bus.gray_in;
    assign sample_ready = 1'b1;
`endif

    // Each binary bit is the XOR of all Gray bits at or above it
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_conv
            assign bin_comb[gi] = ^sample[N-1:gi];
        end
    endgenerate

    assign delta     = bin_comb - bin_reg;
    assign good_step = (delta == N'(1));
    assign hold_step = (delta == '0);

    always_comb begin
        state_next    = state_reg;
        ok_cnt_next   = ok_cnt_reg;
        step_err_next = 1'b0;
        err_event     = 1'b0;
        valid_next    = valid_reg;
        bin_next      = bin_reg;
        case (state_reg)
            IDLE: begin
                if (sample_ready) begin
                    bin_next    = bin_comb;
                    valid_next  = 1'b1;
                    ok_cnt_next = '0;
                    state_next  = ACQUIRE;
                end
            end
            ACQUIRE: begin
                bin_next = bin_comb;
                if (good_step) begin
                    ok_cnt_next = ok_cnt_reg + OKW'(1);
                    if (ok_cnt_reg == OKW'(LOCK_CNT - 1))
                        state_next = LOCKED;
                end else if (!hold_step) begin
                    ok_cnt_next = '0;
                end
            end
            LOCKED: begin
                bin_next = bin_comb;
                if (!good_step && !hold_step) begin
                    step_err_next = 1'b1;
                    err_event     = 1'b1;
                    ok_cnt_next   = '0;
                    state_next    = ACQUIRE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A fresh error outranks a simultaneous clear, so the count restarts at one
        if (bus.clear_err)
            err_next = err_event ? ERR_W'(1) : '0;
        else if (err_event && (err_reg != '1))
            err_next = err_reg + ERR_W'(1);
        else
            err_next = err_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ok_cnt_reg   <= '0;
            bin_reg      <= '0;
            valid_reg    <= 1'b0;
            step_err_reg <= 1'b0;
            err_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            ok_cnt_reg   <= ok_cnt_next;
            bin_reg      <= bin_next;
            valid_reg    <= valid_next;
            step_err_reg <= step_err_next;
            err_reg      <= err_next;
        end
    end

    assign bus.bin_out   = bin_reg;
    assign bus.bin_valid = valid_reg;
    assign bus.locked    = (state_reg == LOCKED);
    assign bus.step_err  = step_err_reg;
    assign bus.err_count = err_reg;
endmodule
